logic_result_stage: RTL and testbench

Output stage directly downstream of the 4-bit logical unit: captures its AND/OR/XOR (4-bit) and NOT (8-bit) results, selects one per request by opcode, tags it with zero/parity flags and buffers it in a small FIFO. Results leave over a valid/ready handshake, so a stalled consumer never drops logical-unit output. A wrapping completion counter reports how many results have been delivered.

---
 rtl/logic_result_stage_if.sv | 32 +++
 rtl/logic_result_stage.sv | 95 +++++++++
 tb/tb_logic_result_stage.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/logic_result_stage_if.sv
// Handshake bundle between the logical unit, the result stage and its consumer.
interface logic_result_stage_if #(
    parameter int unsigned CW = 3
);
    logic          in_valid;
    logic          in_ready;
    logic [1:0]    op;
    logic [3:0]    and_in;
    logic [3:0]    or_in;
    logic [3:0]    xor_in;
    logic [7:0]    not_in;
    logic          out_valid;
    logic          out_ready;
    logic [7:0]    out_result;
    logic [1:0]    out_op;
    logic          out_zero;
    logic          out_parity;
    logic [CW-1:0] level;
    logic [7:0]    done_cnt;

    modport slave (
        input  in_valid, op, and_in, or_in, xor_in, not_in, out_ready,
        output in_ready, out_valid, out_result, out_op, out_zero, out_parity,
               level, done_cnt
    );

    modport master (
        output in_valid, op, and_in, or_in, xor_in, not_in, out_ready,
        input  in_ready, out_valid, out_result, out_op, out_zero, out_parity,
               level, done_cnt
    );
endinterface

// File: rtl/logic_result_stage.sv
// Selects one logical-unit result per request, tags it with zero/parity flags and
// buffers it in a circular FIFO drained over valid/ready; counts delivered results.
module logic_result_stage #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CW    = 3
) (
    input  logic clk,
    input  logic rst_n,
    logic_result_stage_if.slave bus
);
    localparam int unsigned   AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CW-1:0] LVL_FULL = CW'(DEPTH);

    typedef enum logic [1:0] {
        OP_AND = 2'b00,
        OP_OR  = 2'b01,
        OP_XOR = 2'b10,
        OP_NOT = 2'b11
    } op_e;

    logic [11:0]   r_mem [DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [CW-1:0] r_level;
    logic [7:0]    r_done;

    logic          w_in_ready;
    logic          w_out_valid;
    logic          w_push;
    logic          w_pop;
    logic [7:0]    w_sel;
    logic [11:0]   w_entry;
    logic [11:0]   w_head;

    // Ready/valid come only from registered occupancy, so a pop never frees a slot
    // for a push in the same cycle.
    assign w_in_ready  = (r_level != LVL_FULL);
    assign w_out_valid = (r_level != '0);
    assign w_push      = bus.in_valid && w_in_ready;
    assign w_pop       = w_out_valid && bus.out_ready;

    always_comb begin
        w_sel = '0;
        case (op_e'(bus.op))
            OP_AND:  w_sel = {4'h0, bus.and_in};
            OP_OR:   w_sel = {4'h0, bus.or_in};
            OP_XOR:  w_sel = {4'h0, bus.xor_in};
            OP_NOT:  w_sel = bus.not_in;
            default: w_sel = '0;
        endcase
    end

    // Entry layout: [11:10] op, [9:2] result, [1] zero, [0] parity.
    assign w_entry = {bus.op, w_sel, (w_sel == 8'h00), ^w_sel};

    // Storage is left unreset; occupancy alone decides what is visible.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= w_entry;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_level <= '0;
            r_done  <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
                r_done <= r_done + 8'd1;
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end

    assign w_head = r_mem[r_rptr];

    assign bus.in_ready   = w_in_ready;
    assign bus.out_valid  = w_out_valid;
    assign bus.out_op     = w_out_valid ? w_head[11:10] : '0;
    assign bus.out_result = w_out_valid ? w_head[9:2]   : '0;
    assign bus.out_zero   = w_out_valid ? w_head[1]     : 1'b0;
    assign bus.out_parity = w_out_valid ? w_head[0]     : 1'b0;
    assign bus.level      = r_level;
    assign bus.done_cnt   = r_done;
endmodule

// File: tb/tb_logic_result_stage.sv
// Directed self-checking bench for logic_result_stage: reset, per-op select,
// backpressure, full-with-pop, counter wrap and asynchronous mid-stream reset.
module tb_logic_result_stage;
    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;

    logic_result_stage_if #(.CW(3)) bus ();

    logic_result_stage #(.DEPTH(4), .CW(3)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [1:0] o, input logic [3:0] a,
                         input logic [3:0] r, input logic [3:0] x, input logic [7:0] n);
        bus.in_valid = v;
        bus.op       = o;
        bus.and_in   = a;
        bus.or_in    = r;
        bus.xor_in   = x;
        bus.not_in   = n;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.out_ready = 1'b1;
        drive(1'b1, 2'b00, 4'hA, 4'h0, 4'h0, 8'h00);
        repeat (3) tick();
        n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got=%b exp=1", bus.in_ready); end
        n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got=%b exp=0", bus.out_valid); end
        n_checks++; if (bus.level !== 3'd0) begin n_fail++; $display("FAIL reset_level got=%0d exp=0", bus.level); end
        n_checks++; if (bus.done_cnt !== 8'd0) begin n_fail++; $display("FAIL reset_done got=%0d exp=0", bus.done_cnt); end
        n_checks++; if (bus.out_result !== 8'h00) begin n_fail++; $display("FAIL reset_result got=%h exp=00", bus.out_result); end
        drive(1'b0, 2'b00, 4'h0, 4'h0, 4'h0, 8'h00);
        rst_n = 1'b1;
        tick();
        n_checks++; if (bus.level !== 3'd0) begin n_fail++; $display("FAIL post_reset_level got=%0d exp=0", bus.level); end
    endtask

    // Vectors: op, and, or, xor, not, expected result, zero, parity
    task automatic test_op_select();
        logic [1:0] v_op  [6] = '{2'b00, 2'b01, 2'b10, 2'b11, 2'b00, 2'b11};
        logic [3:0] v_and [6] = '{4'hA, 4'hF, 4'h1, 4'h0, 4'h7, 4'hF};
        logic [3:0] v_or  [6] = '{4'hF, 4'h5, 4'h2, 4'h0, 4'h8, 4'hF};
        logic [3:0] v_xor [6] = '{4'h3, 4'hC, 4'h0, 4'h0, 4'h8, 4'hF};
        logic [7:0] v_not [6] = '{8'hFF, 8'h00, 8'h11, 8'h3C, 8'h81, 8'h80};
        logic [7:0] e_res [6] = '{8'h0A, 8'h05, 8'h00, 8'h3C, 8'h07, 8'h80};
        logic       e_z   [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        logic       e_p   [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        bus.out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, v_op[i], v_and[i], v_or[i], v_xor[i], v_not[i]);
            tick();
            n_checks++; if (bus.out_valid !== 1'b1 || bus.level !== 3'd1) begin n_fail++; $display("FAIL op_valid[%0d] got valid=%b level=%0d exp valid=1 level=1", i, bus.out_valid, bus.level); end
            n_checks++; if (bus.out_result !== e_res[i]) begin n_fail++; $display("FAIL op_result[%0d] got=%h exp=%h", i, bus.out_result, e_res[i]); end
            n_checks++; if (bus.out_op !== v_op[i]) begin n_fail++; $display("FAIL op_op[%0d] got=%b exp=%b", i, bus.out_op, v_op[i]); end
            n_checks++; if (bus.out_zero !== e_z[i] || bus.out_parity !== e_p[i]) begin n_fail++; $display("FAIL op_flags[%0d] got z=%b p=%b exp z=%b p=%b", i, bus.out_zero, bus.out_parity, e_z[i], e_p[i]); end
        end
        drive(1'b0, 2'b00, 4'h0, 4'h0, 4'h0, 8'h00);
        tick();
        n_checks++; if (bus.done_cnt !== 8'd6) begin n_fail++; $display("FAIL op_done got=%0d exp=6", bus.done_cnt); end
        n_checks++; if (bus.level !== 3'd0 || bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL op_drained got level=%0d valid=%b exp 0/0", bus.level, bus.out_valid); end
    endtask

    task automatic test_backpressure();
        bus.out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 2'b11, 4'h0, 4'h0, 4'h0, 8'h10 + 8'(i));
            tick();
        end
        drive(1'b1, 2'b11, 4'h0, 4'h0, 4'h0, 8'h14);
        n_checks++; if (bus.level !== 3'd4 || bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_full got level=%0d in_ready=%b exp 4/0", bus.level, bus.in_ready); end
        tick();
        n_checks++; if (bus.level !== 3'd4 || bus.out_result !== 8'h10) begin n_fail++; $display("FAIL bp_hold got level=%0d head=%h exp 4/10", bus.level, bus.out_result); end
        bus.out_ready = 1'b1;
        tick();
        n_checks++; if (bus.level !== 3'd3 || bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_pop got level=%0d in_ready=%b exp 3/1", bus.level, bus.in_ready); end
        bus.out_ready = 1'b0;
        tick();
        n_checks++; if (bus.level !== 3'd4) begin n_fail++; $display("FAIL bp_fifth got level=%0d exp=4", bus.level); end
        drive(1'b0, 2'b00, 4'h0, 4'h0, 4'h0, 8'h00);
        bus.out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            n_checks++; if (bus.out_result !== 8'h11 + 8'(k)) begin n_fail++; $display("FAIL bp_order[%0d] got=%h exp=%h", k, bus.out_result, 8'h11 + 8'(k)); end
            tick();
        end
        n_checks++; if (bus.out_valid !== 1'b0 || bus.done_cnt !== 8'd11) begin n_fail++; $display("FAIL bp_end got valid=%b done=%0d exp 0/11", bus.out_valid, bus.done_cnt); end
    endtask

    task automatic test_full_pop();
        bus.out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 2'b11, 4'h0, 4'h0, 4'h0, 8'h20 + 8'(i));
            tick();
        end
        drive(1'b1, 2'b11, 4'h0, 4'h0, 4'h0, 8'h55);
        bus.out_ready = 1'b1;
        n_checks++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL fp_ready_before got=%b exp=0", bus.in_ready); end
        tick();
        n_checks++; if (bus.level !== 3'd3 || bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL fp_pop_only got level=%0d in_ready=%b exp 3/1", bus.level, bus.in_ready); end
        drive(1'b0, 2'b00, 4'h0, 4'h0, 4'h0, 8'h00);
        for (int k = 0; k < 3; k++) begin
            n_checks++; if (bus.out_result !== 8'h21 + 8'(k)) begin n_fail++; $display("FAIL fp_order[%0d] got=%h exp=%h", k, bus.out_result, 8'h21 + 8'(k)); end
            tick();
        end
        n_checks++; if (bus.out_valid !== 1'b0 || bus.done_cnt !== 8'd15) begin n_fail++; $display("FAIL fp_end got valid=%b done=%0d exp 0/15", bus.out_valid, bus.done_cnt); end
    endtask

    task automatic test_back_to_back();
        int bad;
        bad = 0;
        bus.out_ready = 1'b1;
        drive(1'b1, 2'b11, 4'h0, 4'h0, 4'h0, 8'h00);
        tick();
        for (int k = 1; k <= 241; k++) begin
            bus.not_in = 8'(k);
            tick();
            if (bus.level !== 3'd1 || bus.out_result !== 8'(k)) bad++;
        end
        n_checks++; if (bad != 0) begin n_fail++; $display("FAIL b2b_stream got %0d bad cycles exp 0", bad); end
        n_checks++; if (bus.done_cnt !== 8'd0) begin n_fail++; $display("FAIL b2b_wrap got=%0d exp=0", bus.done_cnt); end
        bus.not_in = 8'hF2;
        tick();
        n_checks++; if (bus.done_cnt !== 8'd1 || bus.level !== 3'd1) begin n_fail++; $display("FAIL b2b_after_wrap got done=%0d level=%0d exp 1/1", bus.done_cnt, bus.level); end
        drive(1'b0, 2'b00, 4'h0, 4'h0, 4'h0, 8'h00);
        tick();
        n_checks++; if (bus.done_cnt !== 8'd2 || bus.level !== 3'd0) begin n_fail++; $display("FAIL b2b_drain got done=%0d level=%0d exp 2/0", bus.done_cnt, bus.level); end
    endtask

    task automatic test_reset_mid();
        bus.out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 2'b11, 4'h0, 4'h0, 4'h0, 8'hA0 + 8'(i));
            tick();
        end
        drive(1'b0, 2'b00, 4'h0, 4'h0, 4'h0, 8'h00);
        n_checks++; if (bus.level !== 3'd3) begin n_fail++; $display("FAIL rm_level_before got=%0d exp=3", bus.level); end
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++; if (bus.out_valid !== 1'b0 || bus.level !== 3'd0) begin n_fail++; $display("FAIL rm_async got valid=%b level=%0d exp 0/0", bus.out_valid, bus.level); end
        n_checks++; if (bus.done_cnt !== 8'd0 || bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL rm_async_cnt got done=%0d in_ready=%b exp 0/1", bus.done_cnt, bus.in_ready); end
        tick();
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        tick();
        n_checks++; if (bus.out_valid !== 1'b0 || bus.done_cnt !== 8'd0) begin n_fail++; $display("FAIL rm_after got valid=%b done=%0d exp 0/0", bus.out_valid, bus.done_cnt); end
        drive(1'b1, 2'b11, 4'h0, 4'h0, 4'h0, 8'h77);
        tick();
        drive(1'b0, 2'b00, 4'h0, 4'h0, 4'h0, 8'h00);
        n_checks++; if (bus.out_result !== 8'h77 || bus.level !== 3'd1) begin n_fail++; $display("FAIL rm_new_head got=%h level=%0d exp 77/1", bus.out_result, bus.level); end
        tick();
        n_checks++; if (bus.out_valid !== 1'b0 || bus.done_cnt !== 8'd1) begin n_fail++; $display("FAIL rm_drain got valid=%b done=%0d exp 0/1", bus.out_valid, bus.done_cnt); end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_op_select();
        test_backpressure();
        test_full_pop();
        test_back_to_back();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
